div_sequencer: RTL and testbench
================================

# div_sequencer

Multi-cycle divide controller for the V850 execute stage. It accepts one DIV/DIVU operation per handshake, performs a 32-iteration restoring division, and applies sign fix-up. Quotient and remainder are written back to the general-register file through its single write port on two consecutive cycles, and the PSW flag update is issued once per operation. It replaces the single-cycle divide path in the executer; the executer stalls on `busy_o`.

## Interface
- `XLEN`, 32, operand/result width (only 32 is supported)
- `IDX`, 5, register-index width
- `clk`  in  1  clock; all state changes on the rising edge
- `rst`  in  1  reset, synchronous, active-high
- `start_i`  in  1  request valid; accepted only when `ready_o`=1
- `ready_o`  out  1  high in IDLE only
- `busy_o`  out  1  inverse of `ready_o`
- `signed_i`  in  1  1 = DIV (signed), 0 = DIVU
- `dividend_i`  in  32  reg2 value
- `divisor_i`  in  32  reg1 value
- `dest_q_i`  in  5  quotient destination register
- `dest_r_i`  in  5  remainder destination register
- `flush_i`  in  1  abort the in-flight operation (branch/exception)
- `wb_en_o`  out  1  GR write strobe
- `wb_addr_o`  out  5  GR write index
- `wb_data_o`  out  32  GR write data
- `flag_we_o`  out  1  PSW OV/S/Z write strobe
- `flag_ov_o`, `flag_s_o`, `flag_z_o`  out  1 each  PSW[2], PSW[1], PSW[0] values
- `done_o`  out  1  one-cycle pulse when the operation retires

## Operation
- States: IDLE, CHECK, DIVIDE, FIXUP, WB_Q, WB_R.
- IDLE: when `start_i`=1, latch the operands, indices and `signed_i`, then go to CHECK.
- CHECK: classify the operation.
  - Divisor 0: go to WB_R with the register writes suppressed. Flags: OV=1, S=0, Z=0. GR is unchanged.
  - Signed, dividend 0x80000000, divisor 0xFFFFFFFF: q=0x80000000, r=0, OV=1, S=1, Z=0. Go to WB_Q.
  - Otherwise: load the magnitudes. Signed operands are converted to absolute value; unsigned operands pass unchanged. Go to DIVIDE.
- DIVIDE: one restoring step per cycle using a 33-bit partial remainder and a 6-bit counter (0..31). Leave after the 32nd step.
- FIXUP (signed only):
  - Negate the quotient if the operand signs differ.
  - Negate the remainder if the dividend is negative, so the remainder sign follows the dividend.
  - Quotient truncates toward zero.
  - Flags: OV=0, S=q[31], Z=(q==0).
- WB_Q: write the quotient to `dest_q_i`.
- WB_R: write the remainder to `dest_r_i`, assert `flag_we_o` and `done_o`, then go to IDLE.
- Writes to index 0 are suppressed (`wb_en_o`=0), since r0 is hard-wired to zero.
- If `dest_q_i`==`dest_r_i`, both writes are issued and the remainder wins.
- `flush_i` in any non-IDLE state: go to IDLE next cycle. No further `wb_en_o`, `flag_we_o` or `done_o` is issued for that operation. If the quotient was already written in WB_Q, that write stands.
- `flush_i` in IDLE is ignored; a `start_i` in the same cycle is still accepted.
- `start_i` while busy is ignored. Operands need not be held after acceptance.

## Timing
- Reset values: state=IDLE, `ready_o`=1, `busy_o`=0. All strobes (`wb_en_o`, `flag_we_o`, `done_o`) are 0. `wb_addr_o`, `wb_data_o` and all flag outputs are 0.
- `rst` mid-operation aborts it with no writeback; `rst` has priority over `flush_i` and `start_i`.
- Accept edge = T.
- Normal operation: CHECK at T+1, DIVIDE at T+2..T+33, FIXUP at T+34, WB_Q at T+35, WB_R/`done_o` at T+36. `ready_o`=1 at T+37.
- Overflow case: WB_Q at T+2, WB_R at T+3.
- Divide-by-zero: WB_R at T+2.
- Back-to-back: a new `start_i` can be accepted in the first IDLE cycle after `done_o`.
- All outputs are registered. Strobes are high for exactly one cycle each.

## Test plan
- DIVU 100/7, dest_q=3, dest_r=4: r3=14 at T+35, r4=2 at T+36; OV=0, S=0, Z=0; `done_o` at T+36.
- DIV 0xFFFFFFF9/2 (−7/2): q=0xFFFFFFFD, r=0xFFFFFFFF; S=1, Z=0, OV=0.
- DIV 5/0: no `wb_en_o` pulses; `flag_we_o` with OV=1, S=0, Z=0 and `done_o` at T+2.
- DIV 0x80000000/0xFFFFFFFF: q=0x80000000, r=0; OV=1, S=1, Z=0; `done_o` at T+3.
- `flush_i` at T+10: IDLE at T+11, no strobes. A new DIVU 9/3 is accepted at T+11 and yields q=3, r=0, Z=0.
- dest_q=0, dest_r=5, DIVU 7/7: no write at WB_Q, r5=0; Z=0 (q=1). Separately, a `start_i` pulsed during DIVIDE is ignored, with no extra `done_o`.

Source files
------------

// File: rtl/div_sequencer.sv
// div_sequencer: multi-cycle restoring DIV/DIVU controller with GR writeback and PSW flag update
module div_sequencer #(
   parameter int XLEN = 32,
   parameter int IDX  = 5
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            start_i,
   output logic            ready_o,
   output logic            busy_o,
   input  logic            signed_i,
   input  logic [XLEN-1:0] dividend_i,
   input  logic [XLEN-1:0] divisor_i,
   input  logic [IDX-1:0]  dest_q_i,
   input  logic [IDX-1:0]  dest_r_i,
   input  logic            flush_i,
   output logic            wb_en_o,
   output logic [IDX-1:0]  wb_addr_o,
   output logic [XLEN-1:0] wb_data_o,
   output logic            flag_we_o,
   output logic            flag_ov_o,
   output logic            flag_s_o,
   output logic            flag_z_o,
   output logic            done_o
);
   typedef enum logic [2:0] {IDLE, CHECK, DIVIDE, FIXUP, WB_Q, WB_R} state_t;
   localparam logic [XLEN-1:0] MIN = {1'b1, {(XLEN-1){1'b0}}};
   state_t state, next;
   logic sgn, nowr, ov, sf, zf;
   logic [XLEN-1:0] a, b, quo, dvs, rem, qf;
   logic [XLEN:0] diff;
   logic [IDX-1:0] dq, dr;
   logic [5:0] cnt;
   // quo shifts the dividend magnitude out while quotient bits shift in
   assign diff = {rem, quo[XLEN-1]} - {1'b0, dvs};
   assign qf = (sgn && (a[XLEN-1] ^ b[XLEN-1])) ? -quo : quo;
   always_ff @(posedge clk)
      if (rst) state <= IDLE;
      else state <= next;
   always_comb begin
      next = state;
      if (state != IDLE && flush_i) next = IDLE;
      else
         case (state)
            IDLE:    next = start_i ? CHECK : IDLE;
            CHECK:   next = b == '0 ? WB_R : (sgn && a == MIN && b == '1) ? WB_Q : DIVIDE;
            DIVIDE:  next = cnt == 6'd31 ? FIXUP : DIVIDE;
            FIXUP:   next = WB_Q;
            WB_Q:    next = WB_R;
            default: next = IDLE;
         endcase
   end
   always_ff @(posedge clk)
      if (rst) begin
         ready_o <= 1'b1;
         busy_o <= 1'b0;
         wb_en_o <= 1'b0;
         wb_addr_o <= '0;
         wb_data_o <= '0;
         flag_we_o <= 1'b0;
         {flag_ov_o, flag_s_o, flag_z_o} <= 3'b000;
         done_o <= 1'b0;
         {sgn, nowr, ov, sf, zf} <= 5'b0;
         {a, b, quo, dvs, rem} <= '0;
         {dq, dr} <= '0;
         cnt <= '0;
      end else begin
         ready_o <= next == IDLE;
         busy_o <= next != IDLE;
         wb_en_o <= !flush_i && !nowr && ((state == WB_Q && dq != '0) || (state == WB_R && dr != '0));
         flag_we_o <= state == WB_R && !flush_i;
         done_o <= state == WB_R && !flush_i;
         if (state == WB_Q || state == WB_R) begin
            wb_addr_o <= state == WB_Q ? dq : dr;
            wb_data_o <= state == WB_Q ? quo : rem;
         end
         if (state == WB_R && !flush_i) {flag_ov_o, flag_s_o, flag_z_o} <= {ov, sf, zf};
         case (state)
            IDLE: if (start_i) begin
               {sgn, a, b, dq, dr} <= {signed_i, dividend_i, divisor_i, dest_q_i, dest_r_i};
               nowr <= 1'b0;
            end
            CHECK: begin
               rem <= '0;
               cnt <= '0;
               if (b == '0) {nowr, ov, sf, zf} <= 4'b1100;
               else if (sgn && a == MIN && b == '1) begin
                  quo <= MIN;
                  {ov, sf, zf} <= 3'b110;
               end else begin
                  quo <= (sgn && a[XLEN-1]) ? -a : a;
                  dvs <= (sgn && b[XLEN-1]) ? -b : b;
               end
            end
            DIVIDE: begin
               rem <= diff[XLEN] ? {rem[XLEN-2:0], quo[XLEN-1]} : diff[XLEN-1:0];
               quo <= {quo[XLEN-2:0], ~diff[XLEN]};
               cnt <= cnt + 6'd1;
            end
            FIXUP: begin
               quo <= qf;
               rem <= (sgn && a[XLEN-1]) ? -rem : rem;
               {ov, sf, zf} <= {1'b0, qf[XLEN-1], qf == '0};
            end
            default: ;
         endcase
      end
endmodule

// File: tb/tb_div_sequencer.sv
// tb_div_sequencer: randomized and directed checks of div_sequencer against an arithmetic model
module tb_div_sequencer;
   logic clk = 0, rst = 1, start_i = 0, signed_i = 0, flush_i = 0;
   logic [31:0] dividend_i = 0, divisor_i = 0;
   logic [4:0] dest_q_i = 0, dest_r_i = 0;
   logic ready_o, busy_o, wb_en_o, flag_we_o, flag_ov_o, flag_s_o, flag_z_o, done_o;
   logic [4:0] wb_addr_o;
   logic [31:0] wb_data_o;
   int n_cmp = 0, n_err = 0;

   div_sequencer #(.XLEN(32), .IDX(5)) dut (
      .clk(clk), .rst(rst), .start_i(start_i), .ready_o(ready_o), .busy_o(busy_o),
      .signed_i(signed_i), .dividend_i(dividend_i), .divisor_i(divisor_i),
      .dest_q_i(dest_q_i), .dest_r_i(dest_r_i), .flush_i(flush_i),
      .wb_en_o(wb_en_o), .wb_addr_o(wb_addr_o), .wb_data_o(wb_data_o),
      .flag_we_o(flag_we_o), .flag_ov_o(flag_ov_o), .flag_s_o(flag_s_o),
      .flag_z_o(flag_z_o), .done_o(done_o));

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
      end
   endtask

   // drives one operation from acceptance to retirement (or flush) and checks every cycle
   task automatic run_op(input logic s, input logic [31:0] a, input logic [31:0] b,
                         input logic [4:0] qi, input logic [4:0] ri, input int flush_k, input bit poke);
      logic [31:0] q, r;
      logic [2:0] fl;
      longint sa, sb;
      int lat, lim;
      bit en;
      if (b == 0) begin
         q = 0; r = 0; fl = 3'b100; lat = 2;
      end else if (s && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
         q = 32'h8000_0000; r = 0; fl = 3'b110; lat = 3;
      end else begin
         if (s) begin
            sa = longint'($signed(a)); sb = longint'($signed(b));
            q = 32'(sa / sb); r = 32'(sa % sb);
         end else begin
            q = a / b; r = a % b;
         end
         fl = {1'b0, q[31], q == 0}; lat = 36;
      end
      lim = flush_k > 0 ? flush_k : lat;
      check("ready", 32'(ready_o), 1);
      check("busy", 32'(busy_o), 0);
      {start_i, signed_i, dividend_i, divisor_i, dest_q_i, dest_r_i} = {1'b1, s, a, b, qi, ri};
      @(posedge clk);
      @(negedge clk);
      start_i = 0;
      {signed_i, dividend_i, divisor_i, dest_q_i, dest_r_i} = {$urandom, $urandom, $urandom, $urandom, $urandom};
      for (int k = 1; k <= lim; k++) begin
         @(posedge clk);
         @(negedge clk);
         en = flush_k == 0 && b != 0 && ((k == lat - 1 && qi != 0) || (k == lat && ri != 0));
         check("wb_en", 32'(wb_en_o), 32'(en));
         if (en) begin
            check("wb_addr", 32'(wb_addr_o), 32'(k == lat ? ri : qi));
            check("wb_data", wb_data_o, k == lat ? r : q);
         end
         check("done", 32'(done_o), 32'(flush_k == 0 && k == lat));
         check("flag_we", 32'(flag_we_o), 32'(flush_k == 0 && k == lat));
         if (flush_k == 0 && k == lat) check("flags", 32'({flag_ov_o, flag_s_o, flag_z_o}), 32'(fl));
         if (k < lim - 1) check("busy_mid", 32'(busy_o), 1);
         flush_i = flush_k > 0 && k == flush_k - 1;
         start_i = poke && k == 5;
      end
      flush_i = 0;
      start_i = 0;
   endtask

   initial begin
      repeat (2) @(posedge clk);
      @(negedge clk);
      check("rst_ready", 32'(ready_o), 1);
      check("rst_busy", 32'(busy_o), 0);
      check("rst_strobes", 32'({wb_en_o, flag_we_o, done_o}), 0);
      check("rst_addr", 32'(wb_addr_o), 0);
      check("rst_data", wb_data_o, 0);
      check("rst_flags", 32'({flag_ov_o, flag_s_o, flag_z_o}), 0);
      rst = 0;
      @(negedge clk);
      run_op(0, 100, 7, 3, 4, 0, 0);
      run_op(1, 32'hFFFF_FFF9, 2, 6, 7, 0, 0);
      run_op(1, 5, 0, 8, 9, 0, 0);
      run_op(1, 32'h8000_0000, 32'hFFFF_FFFF, 10, 11, 0, 0);
      run_op(0, 20, 3, 12, 13, 10, 0);
      run_op(0, 9, 3, 14, 15, 0, 0);
      run_op(0, 7, 7, 0, 5, 0, 1);
      run_op(1, 32'hFFFF_FF9C, 32'hFFFF_FFF9, 2, 2, 0, 0);
      run_op(1, 32'h8000_0000, 3, 1, 0, 0, 0);
      run_op(0, 32'h8000_0000, 32'hFFFF_FFFF, 16, 17, 0, 0);
      for (int i = 0; i < 24; i++) begin
         logic [31:0] a, b;
         a = $urandom;
         b = $urandom_range(0, 3) == 0 ? $urandom_range(0, 20) : $urandom;
         if (i % 8 == 3) begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
         if ($urandom_range(0, 1) == 1) b = b >> $urandom_range(0, 31);
         run_op(1'($urandom), a, b, 5'($urandom), 5'($urandom), 0, 1'($urandom));
      end
      // reset in the middle of an operation must discard it
      start_i = 1; signed_i = 0; dividend_i = 50; divisor_i = 5; dest_q_i = 1; dest_r_i = 2;
      @(posedge clk);
      @(negedge clk);
      start_i = 0;
      repeat (10) @(posedge clk);
      @(negedge clk);
      rst = 1;
      @(posedge clk);
      @(negedge clk);
      rst = 0;
      check("mid_rst_ready", 32'(ready_o), 1);
      check("mid_rst_flags", 32'({flag_ov_o, flag_s_o, flag_z_o}), 0);
      check("mid_rst_data", wb_data_o, 0);
      for (int k = 0; k < 40; k++) begin
         @(posedge clk);
         @(negedge clk);
         check("mid_rst_quiet", 32'({wb_en_o, flag_we_o, done_o}), 0);
      end
      run_op(0, 50, 5, 1, 2, 0, 0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule
